conv2_kernel_fetch: RTL and testbench
=====================================

Name: conv2_kernel_fetch

Overview:
Sequencer for the conv2 group kernel weight ROM (256 x 16-bit, dual read port, one-cycle registered read). On a start command it walks one KERNEL_SIZE-word kernel out of the ROM, two words per beat using both ports. It presents the weights to the conv2 MAC array as a valid/ready stream at full throughput under backpressure. It sits between the layer control FSM and the ROM instance; one fetcher per kernel ROM.

Parameters:
ADDR_W, 8, ROM address width.
DATA_W, 16, weight word width.
KERNEL_SIZE, 25, words per kernel (5x5); must be >= 1.
NUM_KERNELS, 10, kernels stored back-to-back from address 0; NUM_KERNELS*KERNEL_SIZE <= 2**ADDR_W, enforced by elaboration check.
IDX_W, 4, width of kernel_idx.

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  fetch request, sampled only in IDLE
kernel_idx  in  IDX_W  kernel number, sampled with start
abort  in  1  synchronous cancel, return to IDLE next edge
busy  out  1  high while state != IDLE
done  out  1  one-cycle pulse after final beat or error
err  out  1  one-cycle pulse, coincident with done, for kernel_idx >= NUM_KERNELS
rom_addr_a  out  ADDR_W  ROM port A address (combinational next-pointer)
rom_addr_b  out  ADDR_W  ROM port B address
rom_q_a  in  DATA_W  ROM port A data
rom_q_b  in  DATA_W  ROM port B data
w_data_a  out  DATA_W  even weight of beat (= rom_q_a)
w_data_b  out  DATA_W  odd weight of beat (= rom_q_b)
w_valid  out  1  beat valid
w_b_valid  out  1  w_data_b meaningful (low only on final beat of odd-size kernel)
w_last  out  1  final beat of kernel
w_ready  in  1  consumer accepts beat

Behaviour:
- Reset (async, reset_n low): state IDLE; ptr=0, cnt=0; busy, done, err, w_valid, w_b_valid, w_last = 0; rom_addr_a=0, rom_addr_b=1.
- Registers: state {IDLE, STREAM, FINISH}, ptr (ADDR_W), cnt (remaining words, width ceil(log2(KERNEL_SIZE+1))).
- Address generation: next_ptr = base on accepted start; ptr+2 on handshake (w_valid & w_ready) in STREAM; else ptr. rom_addr_a = next_ptr. rom_addr_b = next_ptr+1, except when next remaining count == 1, then rom_addr_b = next_ptr (never reads past kernel end). ROM therefore registers the next beat on the same edge as the handshake: zero-bubble throughput.
- base = kernel_idx * KERNEL_SIZE, computed combinationally, ADDR_W bits.
- IDLE: start & kernel_idx < NUM_KERNELS -> ptr=base, cnt=KERNEL_SIZE, STREAM. start & idx out of range -> FINISH with err flag set, ROM not walked. start with abort same cycle: abort wins, stay IDLE.
- STREAM: w_valid=1; w_b_valid = (cnt >= 2); w_last = (cnt <= 2). First beat valid the cycle after start (latency 1). On handshake: cnt -= (cnt >= 2 ? 2 : 1); if w_last, go FINISH. No handshake: ptr, cnt, addresses held, so ROM data stable; w_data stable while w_valid & !w_ready.
- FINISH: done=1 for exactly one cycle (err=1 too if error path), then IDLE. start in FINISH ignored.
- abort in STREAM or FINISH: IDLE next edge, no done pulse, w_valid low next cycle.
- start while busy ignored; kernel_idx sampled only on accepted start.
- Beats per kernel = ceil(KERNEL_SIZE/2); KERNEL_SIZE=1 gives one beat with w_b_valid=0, w_last=1.
- Done-to-next-start: earliest start accepted is the cycle done is high? No: only in IDLE, i.e. the cycle after done.

Test Plan:
- Reset mid-STREAM (idx 2, after 4 beats) -> all outputs 0 immediately, IDLE, no done; fresh start idx 2 restarts at address 50.
- start idx 3, w_ready tied 1 -> 13 consecutive beats, first pair addresses 75/76, last beat data from addr 99 with w_b_valid=0, w_last=1; done pulse cycle after last beat; busy high 14 cycles.
- start idx 0, w_ready toggled random 50% -> w_data/w_last stable while stalled, no dropped or duplicated words; weight sequence equals ROM words 0..24.
- start idx 10 and idx 15 -> no w_valid, done=1 and err=1 one cycle after start, ROM addresses unchanged after.
- abort on beat 6 of idx 9 (base 225) -> IDLE, no done; then start idx 9 -> addresses 225..249 all fetched, rom_addr_b never exceeds 249.
- start pulsed every cycle during streaming -> ignored; back-to-back kernels 1 then 2 with start the cycle after done -> correct base 25 then 50.

Source files
------------

// File: rtl/conv2_kernel_fetch.sv
// Kernel weight fetcher for the conv2 weight ROM: walks one kernel through both
// ROM read ports and streams two weights per beat over a valid/ready handshake.
module conv2_kernel_fetch #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int KERNEL_SIZE = 25,
   parameter int NUM_KERNELS = 10,
   parameter int IDX_W       = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [IDX_W-1:0]  kernel_idx,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] rom_addr_a,
   output logic [ADDR_W-1:0] rom_addr_b,
   input  logic [DATA_W-1:0] rom_q_a,
   input  logic [DATA_W-1:0] rom_q_b,
   output logic [DATA_W-1:0] w_data_a,
   output logic [DATA_W-1:0] w_data_b,
   output logic              w_valid,
   output logic              w_b_valid,
   output logic              w_last,
   input  logic              w_ready
);

   // state   | meaning
   // S_IDLE   | waiting for start
   // S_STREAM | presenting beats, ROM pre-reads the next beat on each handshake
   // S_FINISH | one-cycle done (and err on bad index) pulse

   localparam int CNT_W = $clog2(KERNEL_SIZE + 1);

   generate
      if (KERNEL_SIZE < 1) begin : g_bad_ks
         $error("KERNEL_SIZE must be at least 1");
      end
      if (NUM_KERNELS * KERNEL_SIZE > (2 ** ADDR_W)) begin : g_bad_fit
         $error("NUM_KERNELS*KERNEL_SIZE does not fit in the ROM address space");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_FINISH
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ptr, ptr_nxt, base;
   logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_step;
   logic              err_flag, err_flag_nxt;
   logic              idx_ok, handshake, cnt_ge2, in_stream;

   assign base      = ADDR_W'(32'(kernel_idx) * KERNEL_SIZE);
   assign idx_ok    = (32'(kernel_idx) < NUM_KERNELS);
   assign in_stream = (state == S_STREAM);
   assign cnt_ge2   = (32'(cnt) >= 2);
   assign cnt_step  = cnt_ge2 ? CNT_W'(2) : CNT_W'(1);
   assign handshake = in_stream & w_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         ptr      <= '0;
         cnt      <= '0;
         err_flag <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         cnt      <= cnt_nxt;
         err_flag <= err_flag_nxt;
      end
   end

   // abort overrides everything, including a start or handshake in the same cycle
   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      cnt_nxt      = cnt;
      err_flag_nxt = err_flag;
      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (idx_ok) begin
                     ptr_nxt      = base;
                     cnt_nxt      = CNT_W'(KERNEL_SIZE);
                     err_flag_nxt = 1'b0;
                     state_nxt    = S_STREAM;
                  end else begin
                     err_flag_nxt = 1'b1;
                     state_nxt    = S_FINISH;
                  end
               end
            end
            S_STREAM: begin
               if (handshake) begin
                  ptr_nxt = ptr + ADDR_W'(2);
                  cnt_nxt = cnt - cnt_step;
                  if (w_last) state_nxt = S_FINISH;
               end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   // port B repeats port A on an odd tail so the ROM never reads past the kernel
   assign rom_addr_a = ptr_nxt;
   assign rom_addr_b = (cnt_nxt == CNT_W'(1)) ? ptr_nxt : ptr_nxt + ADDR_W'(1);

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_FINISH) & ~abort;
   assign err       = done & err_flag;
   assign w_valid   = in_stream;
   assign w_b_valid = in_stream & cnt_ge2;
   assign w_last    = in_stream & (32'(cnt) <= 2);
   assign w_data_a  = rom_q_a;
   assign w_data_b  = rom_q_b;

endmodule

// File: tb/tb_conv2_kernel_fetch.sv
// Self-checking bench for conv2_kernel_fetch with a registered dual-port ROM model
// and a beat scoreboard filled at start time and drained on each handshake.
module tb_conv2_kernel_fetch;

   localparam int KS = 25;

   logic        clock, reset_n, start, abort, w_ready;
   logic [3:0]  kernel_idx;
   logic        busy, done, err, w_valid, w_b_valid, w_last;
   logic [7:0]  rom_addr_a, rom_addr_b;
   logic [15:0] rom_q_a, rom_q_b, w_data_a, w_data_b;

   conv2_kernel_fetch dut (
      .clock(clock), .reset_n(reset_n), .start(start), .kernel_idx(kernel_idx),
      .abort(abort), .busy(busy), .done(done), .err(err),
      .rom_addr_a(rom_addr_a), .rom_addr_b(rom_addr_b),
      .rom_q_a(rom_q_a), .rom_q_b(rom_q_b),
      .w_data_a(w_data_a), .w_data_b(w_data_b), .w_valid(w_valid),
      .w_b_valid(w_b_valid), .w_last(w_last), .w_ready(w_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [15:0] rom [256];
   always @(posedge clock) begin
      rom_q_a <= rom[rom_addr_a];
      rom_q_b <= rom[rom_addr_b];
   end

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        bv;
      logic        last;
   } beat_t;

   beat_t sb[$];
   int    vectors = 0;
   int    miscompares = 0;
   int    addr_lo = 0;
   int    addr_hi = 255;

   logic        prev_stall = 1'b0;
   logic [15:0] prev_a, prev_b;
   logic        prev_bv, prev_last;

   // scoreboard drain, stall stability and ROM address window, all at negedge
   always @(negedge clock) begin
      beat_t e;
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && w_valid) begin
            vectors++;
            if ({w_data_a, w_data_b, w_b_valid, w_last} !== {prev_a, prev_b, prev_bv, prev_last}) begin
               miscompares++;
               $display("FAIL stall_hold got %h/%h/%b/%b want %h/%h/%b/%b", w_data_a, w_data_b,
                        w_b_valid, w_last, prev_a, prev_b, prev_bv, prev_last);
            end
         end
         if (w_valid && w_ready) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL sb_extra_beat got a=%h want no beat", w_data_a);
            end else begin
               e = sb.pop_front();
               if ({w_data_a, w_b_valid, w_last} !== {e.a, e.bv, e.last} ||
                   (e.bv && w_data_b !== e.b)) begin
                  miscompares++;
                  $display("FAIL sb_beat got %h/%h bv=%b last=%b want %h/%h bv=%b last=%b",
                           w_data_a, w_data_b, w_b_valid, w_last, e.a, e.b, e.bv, e.last);
               end
            end
         end
         if (w_valid && !abort && !(w_ready && w_last)) begin
            vectors++;
            if (int'(rom_addr_a) < addr_lo || int'(rom_addr_b) > addr_hi) begin
               miscompares++;
               $display("FAIL addr_window got a=%0d b=%0d want %0d..%0d",
                        rom_addr_a, rom_addr_b, addr_lo, addr_hi);
            end
         end
         prev_stall = w_valid && !w_ready;
         prev_a = w_data_a; prev_b = w_data_b; prev_bv = w_b_valid; prev_last = w_last;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_kernel(input int idx);
      beat_t e;
      int    b;
      b = idx * KS;
      for (int w = 0; w < KS; w += 2) begin
         e.a    = rom[b + w];
         e.bv   = (w + 1 < KS);
         e.b    = e.bv ? rom[b + w + 1] : rom[b + w];
         e.last = (w + 2 >= KS);
         sb.push_back(e);
      end
   endtask

   // drives start for one cycle; caller is in IDLE, so a valid idx is accepted
   task automatic start_kernel(input int idx);
      start = 1'b1;
      kernel_idx = 4'(idx);
      if (idx < 10) push_kernel(idx);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int c;
      for (c = 0; c < budget; c++) begin
         @(negedge clock);
         if (done) break;
      end
      vectors++;
      if (c >= budget) begin
         miscompares++;
         $display("FAIL %s timeout got no done want done within %0d cycles", name, budget);
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL %s sb_left got %0d beats want 0", name, sb.size());
      end
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; w_ready = 1'b0; kernel_idx = '0;
      repeat (2) @(negedge clock);
      vectors++;
      if ({busy, done, err, w_valid, w_b_valid, w_last} !== 6'b0 ||
          rom_addr_a !== 8'd0 || rom_addr_b !== 8'd1) begin
         miscompares++;
         $display("FAIL reset_state got flags=%b a=%0d b=%0d want 000000 0 1",
                  {busy, done, err, w_valid, w_b_valid, w_last}, rom_addr_a, rom_addr_b);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_full_rate();
      int beats = 0, busy_n = 0, done_at = -1, first_v = -1, errs = 0;
      addr_lo = 75; addr_hi = 99; w_ready = 1'b1;
      start = 1'b1; kernel_idx = 4'd3; push_kernel(3);
      @(negedge clock);
      vectors++;
      if (rom_addr_a !== 8'd75 || rom_addr_b !== 8'd76) begin
         miscompares++;
         $display("FAIL first_addr got %0d/%0d want 75/76", rom_addr_a, rom_addr_b);
      end
      tick();
      start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (c > 1) tick();
         @(negedge clock);
         if (w_valid) beats++;
         if (w_valid && first_v < 0) first_v = c;
         if (busy) busy_n++;
         if (done && done_at < 0) done_at = c;
         if (err) errs++;
      end
      vectors++;
      if (first_v != 1 || beats != 13 || done_at != 14 || busy_n != 14 || errs != 0) begin
         miscompares++;
         $display("FAIL full_rate got first=%0d beats=%0d done_at=%0d busy=%0d err=%0d want 1 13 14 14 0",
                  first_v, beats, done_at, busy_n, errs);
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL full_rate sb_left got %0d want 0", sb.size());
      end
      tick();
   endtask

   task automatic test_stall();
      int c;
      addr_lo = 0; addr_hi = 24;
      w_ready = 1'b0;
      start_kernel(0);
      for (c = 0; c < 300; c++) begin
         @(negedge clock);
         if (done) break;
         tick();
         w_ready = 1'($urandom_range(0, 1));
      end
      vectors++;
      if (c >= 300 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL stall_run got cycles=%0d left=%0d want done with 0 left", c, sb.size());
      end
      w_ready = 1'b1;
      tick();
   endtask

   task automatic test_bad_idx(input int idx);
      logic [7:0] a0, b0;
      @(negedge clock);
      a0 = rom_addr_a; b0 = rom_addr_b;
      tick();
      start_kernel(idx);
      @(negedge clock);
      vectors++;
      if (done !== 1'b1 || err !== 1'b1 || w_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bad_idx_%0d got done=%b err=%b valid=%b want 1 1 0", idx, done, err, w_valid);
      end
      tick();
      @(negedge clock);
      vectors++;
      if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || rom_addr_a !== a0 || rom_addr_b !== b0) begin
         miscompares++;
         $display("FAIL bad_idx_after_%0d got done=%b err=%b busy=%b a=%0d b=%0d want 0 0 0 %0d %0d",
                  idx, done, err, busy, rom_addr_a, rom_addr_b, a0, b0);
      end
      tick();
   endtask

   task automatic test_abort();
      int dones = 0;
      addr_lo = 225; addr_hi = 249; w_ready = 1'b1;
      start_kernel(9);
      repeat (5) tick();
      abort = 1'b1; w_ready = 1'b0;
      tick();
      abort = 1'b0;
      @(negedge clock);
      vectors++;
      if (busy !== 1'b0 || w_valid !== 1'b0 || done !== 1'b0 || sb.size() != 8) begin
         miscompares++;
         $display("FAIL abort_state got busy=%b valid=%b done=%b left=%0d want 0 0 0 8",
                  busy, w_valid, done, sb.size());
      end
      sb.delete();
      for (int c = 0; c < 4; c++) begin
         tick();
         @(negedge clock);
         if (done) dones++;
      end
      vectors++;
      if (dones != 0) begin
         miscompares++;
         $display("FAIL abort_no_done got %0d pulses want 0", dones);
      end
      tick();
      w_ready = 1'b1;
      start_kernel(9);
      wait_done("abort_refetch", 40);
   endtask

   task automatic test_back_to_back();
      int dones = 0;
      addr_lo = 25; addr_hi = 49; w_ready = 1'b1;
      start_kernel(1);
      for (int c = 0; c < 40; c++) begin
         start = 1'b1; kernel_idx = 4'd7;
         @(negedge clock);
         if (done) begin dones++; break; end
         tick();
      end
      tick();
      start = 1'b0;
      vectors++;
      if (dones != 1 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL b2b_first got dones=%0d left=%0d want 1 0", dones, sb.size());
      end
      addr_lo = 50; addr_hi = 74;
      start = 1'b1; kernel_idx = 4'd2; push_kernel(2);
      @(negedge clock);
      vectors++;
      if (rom_addr_a !== 8'd50 || rom_addr_b !== 8'd51 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_second_start got a=%0d b=%0d busy=%b want 50 51 0", rom_addr_a, rom_addr_b, busy);
      end
      tick();
      start = 1'b0;
      wait_done("b2b_second", 40);
   endtask

   task automatic test_reset_mid();
      addr_lo = 50; addr_hi = 74; w_ready = 1'b1;
      start_kernel(2);
      repeat (4) tick();
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({busy, done, err, w_valid, w_b_valid, w_last} !== 6'b0 ||
          rom_addr_a !== 8'd0 || rom_addr_b !== 8'd1) begin
         miscompares++;
         $display("FAIL reset_mid got flags=%b a=%0d b=%0d want 000000 0 1",
                  {busy, done, err, w_valid, w_b_valid, w_last}, rom_addr_a, rom_addr_b);
      end
      sb.delete();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      tick();
      start = 1'b1; kernel_idx = 4'd2; push_kernel(2);
      @(negedge clock);
      vectors++;
      if (rom_addr_a !== 8'd50 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_restart got a=%0d done=%b want 50 0", rom_addr_a, done);
      end
      tick();
      start = 1'b0;
      wait_done("reset_restart", 40);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 16'((i * 16'h0137) ^ 16'hBEEF);
      test_reset();
      test_full_rate();
      test_stall();
      test_bad_idx(10);
      test_bad_idx(15);
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
